// File: rtl/ciphertext_collector_if.sv
// Character stream bundle between the encryption stage, the collector FIFO and its consumer.
// slave = collector side, master = encryption stage plus downstream consumer.
interface ciphertext_collector_if;
    logic [7:0] Char_ciphertext;
    logic       C_ready;
    logic       err_invalid_ptxt;
    logic [7:0] out_char;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  Char_ciphertext, C_ready, err_invalid_ptxt, out_ready,
        output out_char, out_valid
    );

    modport master (
        output Char_ciphertext, C_ready, err_invalid_ptxt, out_ready,
        input  out_char, out_valid
    );
endinterface

// File: rtl/ciphertext_collector.sv
// FWFT FIFO collecting strobed ciphertext characters and replaying them over valid/ready.
// Optional rejected-strobe counter built only with CIPHERTEXT_COLLECTOR_ERRCNT_EN defined.
module ciphertext_collector #(
    parameter int DEPTH     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ciphertext_collector_if.slave  bus,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          wr_en;

    assign push  = bus.C_ready & ~bus.err_invalid_ptxt;
    assign pop   = ~empty & bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop) & ~clear;

    assign full          = (level == LW'(DEPTH));
    assign empty         = (level == '0);
    assign bus.out_valid = ~empty;
    assign bus.out_char  = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push & full & ~pop)
                overflow <= 1'b1;
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= bus.Char_ciphertext;
    end

`ifdef CIPHERTEXT_COLLECTOR_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (clear)
            err_count <= '0;
        else if (bus.C_ready & bus.err_invalid_ptxt & (err_count != {ERR_CNT_W{1'b1}}))
            err_count <= err_count + ERR_CNT_W'(1);
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_ciphertext_collector.sv
// Scoreboard bench for ciphertext_collector: queue-based reference model, monitor checks replay order.
module tb_ciphertext_collector;
    localparam int DEPTH     = 16;
    localparam int ERR_CNT_W = 8;
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 clear = 1'b0;
    logic [LW-1:0]        level;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic [ERR_CNT_W-1:0] err_count;

    ciphertext_collector_if bus();

    ciphertext_collector #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .clear    (clear),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    byte unsigned exp_q[$];
    int mlevel = 0;
    int movf   = 0;
    int merr   = 0;
    int n_vec  = 0;
    int n_bad  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_state();
        chk("level", 32'(level), 32'(mlevel));
        chk("full", 32'(full), 32'(mlevel == DEPTH));
        chk("empty", 32'(empty), 32'(mlevel == 0));
        chk("out_valid", 32'(bus.out_valid), 32'(mlevel != 0));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("err_count", 32'(err_count), 32'(merr));
        if (mlevel == 0)
            chk("out_char_idle", 32'(bus.out_char), 32'h0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mlevel = 0;
        movf   = 0;
        merr   = 0;
    endtask

    // Inputs are applied 1 time unit after an edge; the model commits at the next edge.
    task automatic cycle(input bit cr, input bit er, input byte unsigned ch, input bit rdy, input bit clr);
        bit pop_m;
        bit push_m;
        bit acc;
        bus.C_ready          = cr;
        bus.err_invalid_ptxt = er;
        bus.Char_ciphertext  = ch;
        bus.out_ready        = rdy;
        clear                = clr;
        @(posedge clk);
        pop_m  = rdy && (mlevel > 0);
        push_m = cr && !er;
        if (clr) begin
            model_reset();
        end else begin
            acc = push_m && ((mlevel < DEPTH) || pop_m);
            if (acc)
                exp_q.push_back(ch);
            if (push_m && !acc)
                movf = 1;
            if (acc && !pop_m)
                mlevel++;
            else if (pop_m && !acc)
                mlevel--;
`ifdef CIPHERTEXT_COLLECTOR_ERRCNT_EN
            if (cr && er && (merr < ERR_MAX))
                merr++;
`endif
        end
        #1;
        check_state();
    endtask

    // Monitor: every accepted output character must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL out_unexpected: got %0h, expected no output at %0t", bus.out_char, $time);
            end else begin
                chk("out_char", 32'(bus.out_char), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        bus.C_ready          = 1'b0;
        bus.err_invalid_ptxt = 1'b0;
        bus.Char_ciphertext  = 8'h00;
        bus.out_ready        = 1'b0;
        #12;
        check_state();
        rst = 1'b0;

        // single character round trip
        cycle(1, 0, 8'h7F, 1, 0);
        cycle(0, 0, 8'h00, 1, 0);

        // four characters queued, then drained in order
        for (int i = 0; i < 4; i++)
            cycle(1, 0, 8'(8'h41 + i), 0, 0);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 8'h00, 1, 0);

        // fill, overflow, push+pop while full, drain
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 0, 8'(8'h60 + i), 0, 0);
        cycle(1, 0, 8'hEE, 0, 0);
        cycle(1, 0, 8'hA5, 1, 0);
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 0, 8'h00, 0, 1);

        // rejected strobes
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 8'h33, 0, 0);
`ifdef CIPHERTEXT_COLLECTOR_ERRCNT_EN
        for (int i = 0; i < ERR_MAX + 5; i++)
            cycle(1, 1, 8'h34, 0, 0);
`endif
        cycle(0, 0, 8'h00, 0, 1);

        // randomized traffic in phases of different producer/consumer rates
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 80; i++) begin
                bit cr;
                bit er;
                bit rdy;
                cr  = ($urandom_range(3) < 3 - (ph % 2));
                er  = ($urandom_range(7) == 0);
                rdy = ($urandom_range(3) < 1 + ph);
                cycle(cr, er, 8'($urandom_range(255)), rdy, 0);
            end
        end
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(0, 0, 8'h00, 1, 0);

        // clear together with push and pop at level 5
        for (int i = 0; i < 5; i++)
            cycle(1, 0, 8'(8'h80 + i), 0, 0);
        cycle(1, 1, 8'h00, 0, 0);
        cycle(1, 0, 8'h99, 1, 1);
        cycle(0, 0, 8'h00, 1, 0);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 8'(8'hC0 + i), 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 0, 8'h5A, 1, 0);
        cycle(0, 0, 8'h00, 1, 0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
